// File: rtl/step_sequencer_core_if.sv
// Control, pattern-write and note-output signals between the step sequencer and its host.
// The master modport belongs to the host; the slave modport belongs to the sequencer.
interface step_sequencer_core_if #(
  parameter int unsigned STEP_W = 4
);
  logic              play;
  logic              stop;
  logic              wr_en;
  logic [STEP_W-1:0] wr_step;
  logic [11:0]       wr_data;
  logic [11:0]       select;
  logic [STEP_W-1:0] step;
  logic              step_pulse;
  logic              n_start;
  logic              playing;

  modport master (
    output play, stop, wr_en, wr_step, wr_data,
    input  select, step, step_pulse, n_start, playing
  );

  modport slave (
    input  play, stop, wr_en, wr_step, wr_data,
    output select, step, step_pulse, n_start, playing
  );
endinterface

// File: rtl/step_sequencer_core.sv
// Pattern step sequencer: steps through a 2**STEP_W x 12-bit note-mask pattern at a fixed tempo.
// Optional macro STEP_SEQ_GATE_EN gates Select off once the counter reaches GATE_TICKS in a step.
module step_sequencer_core #(
  parameter int unsigned STEP_W     = 4,
  parameter int unsigned STEP_TICKS = 6250000,
  parameter int unsigned GATE_TICKS = 4687500
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  step_sequencer_core_if.slave  bus_io
);

  localparam int unsigned Steps   = 2 ** STEP_W;
  localparam int unsigned CntW    = $clog2(STEP_TICKS);
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_TICKS - 1);

  if (STEP_TICKS < 2 || GATE_TICKS < 1 || GATE_TICKS > STEP_TICKS) begin : g_param_check
    $error("step_sequencer_core: need STEP_TICKS >= 2 and 1 <= GATE_TICKS <= STEP_TICKS");
  end

  // StEntry is the cycle after ARM in which the first step is loaded.
  typedef enum logic [1:0] {StIdle, StArm, StEntry, StPlay} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d, step_nxt;
  logic [11:0]       word_q, word_d;
  logic [11:0]       sel_q, sel_d;
  logic              pulse_q, pulse_d;
  logic              n_start_q, n_start_d;
  logic              playing_q, playing_d;
  logic [11:0]       pattern_q [Steps];

  assign step_nxt = step_q + STEP_W'(1);

  // Non-blocking write: a read at the same edge still latches the old word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Steps; i++) begin
        pattern_q[i] <= '0;
      end
    end else if (bus_io.wr_en) begin
      pattern_q[bus_io.wr_step] <= bus_io.wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    word_d    = word_q;
    pulse_d   = 1'b0;
    n_start_d = 1'b1;
    playing_d = playing_q;
    if (bus_io.stop) begin
      state_d   = StIdle;
      cnt_d     = '0;
      step_d    = '0;
      word_d    = '0;
      playing_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.play) begin
            state_d   = StArm;
            n_start_d = 1'b0;
            cnt_d     = '0;
            step_d    = '0;
          end
        end
        StArm: begin
          state_d = StEntry;
        end
        StEntry: begin
          state_d   = StPlay;
          cnt_d     = '0;
          step_d    = '0;
          word_d    = pattern_q[0];
          pulse_d   = 1'b1;
          playing_d = 1'b1;
        end
        StPlay: begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            step_d  = step_nxt;
            word_d  = pattern_q[step_nxt];
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
`ifdef STEP_SEQ_GATE_EN
    sel_d = (state_d == StPlay && 32'(cnt_d) < GATE_TICKS) ? word_d : '0;
`else
    sel_d = word_d;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      step_q    <= '0;
      word_q    <= '0;
      sel_q     <= '0;
      pulse_q   <= 1'b0;
      n_start_q <= 1'b1;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      word_q    <= word_d;
      sel_q     <= sel_d;
      pulse_q   <= pulse_d;
      n_start_q <= n_start_d;
      playing_q <= playing_d;
    end
  end

  assign bus_io.select     = sel_q;
  assign bus_io.step       = step_q;
  assign bus_io.step_pulse = pulse_q;
  assign bus_io.n_start    = n_start_q;
  assign bus_io.playing    = playing_q;

endmodule

// File: tb/tb_step_sequencer_core.sv
// Self-checking bench for step_sequencer_core (STEP_W=2, STEP_TICKS=8, GATE_TICKS=3).
// Expected outputs are queued as stimulus is driven and popped after each clock edge.
module tb_step_sequencer_core;

  localparam int unsigned StepW = 2;
  localparam int Tk = 8;
  localparam int Gt = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  step_sequencer_core_if #(.STEP_W(StepW)) bus ();

  step_sequencer_core #(
    .STEP_W    (StepW),
    .STEP_TICKS(8),
    .GATE_TICKS(3)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  typedef struct packed {
    logic [11:0] sel;
    logic        pulse;
    logic [1:0]  step;
    logic        n_start;
    logic        playing;
  } obs_t;

  typedef struct {
    string       name;
    logic [47:0] pat;
    int          n;
    int          wr_at;
    logic [1:0]  ws;
    logic [11:0] wd;
  } vec_t;

  localparam obs_t IdleObs = '{sel: 12'h000, pulse: 1'b0, step: 2'd0, n_start: 1'b1,
                               playing: 1'b0};

  obs_t        sb[$];
  logic [11:0] m_pat [4];
  vec_t        vecs [4];
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic obs_t observe();
    obs_t o;
    o.sel     = bus.select;
    o.pulse   = bus.step_pulse;
    o.step    = bus.step;
    o.n_start = bus.n_start;
    o.playing = bus.playing;
    return o;
  endfunction

  function automatic bit gate_on(input int t);
`ifdef STEP_SEQ_GATE_EN
    return (t % Tk) < Gt;
`else
    return t >= 0;
`endif
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got sel=%h pulse=%b step=%0d nstart=%b playing=%b, want sel=%h pulse=%b step=%0d nstart=%b playing=%b",
               name, $time, act.sel, act.pulse, act.step, act.n_start, act.playing,
               exp.sel, exp.pulse, exp.step, exp.n_start, exp.playing);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [47:0] p);
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_step = 2'(i);
      bus.wr_data = p[i*12 +: 12];
      m_pat[i]    = p[i*12 +: 12];
      cycle();
      check("load_idle", observe(), IdleObs);
    end
    bus.wr_en = 1'b0;
  endtask

  // Pulse Play, then follow n cycles of playback; optionally write one word at cycle wr_at.
  task automatic run(input string name, input int n, input int wr_at, input logic [1:0] ws,
                     input logic [11:0] wd);
    logic [11:0] word;
    obs_t        e;
    int          t;
    word = '0;
    bus.play = 1'b1;
    for (int c = 0; c < n + 2; c++) begin
      if (c == 0) begin
        e = '{sel: 12'h000, pulse: 1'b0, step: 2'd0, n_start: 1'b0, playing: 1'b0};
      end else if (c == 1) begin
        e = IdleObs;
      end else begin
        t = c - 2;
        if (t % Tk == 0) word = m_pat[(t / Tk) % 4];
        e.sel     = gate_on(t) ? word : 12'h000;
        e.pulse   = (t % Tk == 0);
        e.step    = 2'((t / Tk) % 4);
        e.n_start = 1'b1;
        e.playing = 1'b1;
      end
      if (c == wr_at) begin
        bus.wr_en   = 1'b1;
        bus.wr_step = ws;
        bus.wr_data = wd;
        m_pat[ws]   = wd;
      end
      sb.push_back(e);
      cycle();
      bus.play  = 1'b0;
      bus.wr_en = 1'b0;
      check(name, observe(), sb.pop_front());
    end
  endtask

  task automatic stop_check(input string name);
    bus.stop = 1'b1;
    cycle();
    check(name, observe(), IdleObs);
    bus.stop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.play    = 1'b0;
    bus.stop    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_step = '0;
    bus.wr_data = '0;
    rst         = 1'b1;

    vecs[0] = '{name: "basic_wrap", pat: 48'h000_800_010_001, n: 40, wr_at: -1, ws: 2'd0,
                wd: 12'h000};
    vecs[1] = '{name: "write_cur_step", pat: 48'h000_800_010_001, n: 48, wr_at: 12, ws: 2'd1,
                wd: 12'hFFF};
    vecs[2] = '{name: "gate_0a5", pat: 48'h0A5_0A5_0A5_0A5, n: 16, wr_at: -1, ws: 2'd0,
                wd: 12'h000};
    vecs[3] = '{name: "write_at_boundary", pat: 48'h5A5_FFF_123_ABC, n: 36, wr_at: 18,
                ws: 2'd2, wd: 12'h777};

    #1;
    check("reset_async", observe(), IdleObs);
    cycle();
    check("reset_held", observe(), IdleObs);
    rst = 1'b0;
    cycle();
    check("after_reset_idle", observe(), IdleObs);

    // Stop has priority over Play in IDLE.
    bus.play = 1'b1;
    bus.stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("play_stop_idle", observe(), IdleObs);
    end
    bus.play = 1'b0;
    bus.stop = 1'b0;
    cycle();
    check("play_stop_release", observe(), IdleObs);

    for (int v = 0; v < 4; v++) begin
      load(vecs[v].pat);
      run(vecs[v].name, vecs[v].n, vecs[v].wr_at, vecs[v].ws, vecs[v].wd);
      stop_check("stop_after_run");
    end

    load(48'h000_800_010_001);
    run("pre_stop", 19, -1, 2'd0, 12'h000);
    stop_check("stop_step2");
    run("replay", 12, -1, 2'd0, 12'h000);
    stop_check("stop_replay");

    run("pre_reset", 12, -1, 2'd0, 12'h000);
    rst = 1'b1;
    #1;
    check("reset_mid_play", observe(), IdleObs);
    cycle();
    check("reset_mid_play_edge", observe(), IdleObs);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_pat[i] = 12'h000;
    run("after_reset_cleared", 12, -1, 2'd0, 12'h000);
    stop_check("stop_final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
